// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display path: active-low
// segment codes {g,f,e,d,c,b,a}, scan FSM encoding and the anode-off pattern.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Wide enough for the largest supported digit count; slice to NUM_DIGITS.
  localparam logic [7:0] ANODES_OFF = 8'hFF;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Value-load handshake between the producing logic (master) and the scan
// controller (slave).
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    lz_blank_en;
  logic                    ready;

  modport master (output load, output value_in, output lz_blank_en, input ready);
  modport slave  (input load, input value_in, input lz_blank_en, output ready);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD nibbles blank.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: default assignment first so every path drives seg -- no latch.
    seg = SEG_OFF;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: per-digit blank/show slots,
// leading-zero suppression and frame-aligned double-buffered value loads.
module display_scan_ctrl
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS   = 4,
  parameter  int REFRESH_DIV  = 50000,
  parameter  int BLANK_CYCLES = 500,
  localparam int IDX_W        = $clog2(NUM_DIGITS),
  localparam int CNT_W        = $clog2(REFRESH_DIV)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  display_scan_ctrl_if.slave    hs,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_tick
);

  localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODES_OFF[NUM_DIGITS-1:0];

  scan_state_t                 state;
  logic [CNT_W-1:0]            cnt;
  logic                        run;
  logic [NUM_DIGITS-1:0][3:0]  active;
  logic [NUM_DIGITS-1:0][3:0]  shadow;
  logic                        pending;

  logic                        last_cnt;
  logic                        last_digit;
  logic                        show_entry;
  logic                        boundary;
  logic                        accept;
  logic [6:0]                  dec_seg;
  logic [NUM_DIGITS-1:0]       upper_zero;
  logic                        suppress;

  assign last_cnt   = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign last_digit = (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign show_entry = (state == ST_BLANK) && (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign boundary   = run && (state == ST_SHOW) && last_cnt && last_digit;
  assign accept     = hs.load && !pending;
  assign hs.ready   = !pending;

  seg7_decoder u_dec (
    .bcd (active[digit_idx]),
    .seg (dec_seg)
  );

  // upper_zero[i]: nibbles i..NUM_DIGITS-1 of the active value are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (active[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (active[i] == 4'd0);
    end
  end

  assign suppress = hs.lz_blank_en && (digit_idx != '0) && upper_zero[digit_idx];

  // Scan FSM with registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state      <= ST_BLANK;
      cnt        <= '0;
      run        <= 1'b0;
      digit_idx  <= '0;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else if (!run) begin
      // First edge after reset opens frame 0 with the tick asserted.
      run        <= 1'b1;
      frame_tick <= 1'b1;
    end else begin
      frame_tick <= boundary;
      cnt        <= last_cnt ? '0 : cnt + CNT_W'(1);
      unique case (state)
        ST_BLANK: begin
          if (show_entry) begin
            state <= ST_SHOW;
            an    <= suppress ? AN_OFF : ~(NUM_DIGITS'(1) << digit_idx);
            seg   <= suppress ? SEG_OFF : dec_seg;
          end
        end
        ST_SHOW: begin
          if (last_cnt) begin
            state     <= ST_BLANK;
            an        <= AN_OFF;
            seg       <= SEG_OFF;
            digit_idx <= last_digit ? '0 : digit_idx + IDX_W'(1);
          end
        end
        default: state <= ST_BLANK;
      endcase
    end
  end

  // Double buffer: loads land in the shadow and commit only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (boundary) begin
      if (pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (accept) begin
        active <= hs.value_in;
      end
    end else if (accept) begin
      shadow  <= hs.value_in;
      pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (4 digits, 8-cycle slots, 2 blank).
module tb_display_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = N * RD;

  typedef struct packed {
    logic [15:0]     value;
    logic            lz;
    logic [3:0][6:0] seg;
    logic [3:0][3:0] an;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] digit_idx;
  logic       frame_tick;

  int assertions = 0;
  int failures   = 0;
  int frame_no   = 0;
  bit pending_m  = 0;

  vec_t vecs [8];
  vec_t q [$];
  vec_t cur;
  vec_t zero_vec;

  display_scan_ctrl_if #(.NUM_DIGITS(N)) hs ();

  display_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hs         (hs.slave),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (frame %0d): got %0h, expected %0h", name, frame_no, act, exp);
    end
  endtask

  // Step one full frame, checking every cycle; optionally drive loads.
  task automatic run_frame(input vec_t e, input int ld_cyc, input int ld_idx,
                           input int ld2_cyc, input logic [15:0] ld2_val);
    for (int c = 0; c < FRAME; c++) begin
      int slot;
      int cn;
      slot = c / RD;
      cn   = c % RD;
      check("frame_tick", {31'd0, frame_tick}, {31'd0, c == 0});
      check("digit_idx", {30'd0, digit_idx}, slot);
      check("an", {28'd0, an}, {28'd0, (cn < BC) ? 4'hF : e.an[slot]});
      check("seg", {25'd0, seg}, {25'd0, (cn < BC) ? 7'h7F : e.seg[slot]});
      check("ready", {31'd0, hs.ready}, {31'd0, !pending_m});
      hs.load = 1'b0;
      if (c == ld_cyc) begin
        hs.load     = 1'b1;
        hs.value_in = vecs[ld_idx].value;
        if (!pending_m) begin
          q.push_back(vecs[ld_idx]);
          if (c != FRAME - 1) pending_m = 1'b1;
        end
      end else if (c == ld2_cyc) begin
        hs.load     = 1'b1;
        hs.value_in = ld2_val;
      end
      if (c == FRAME - 1) begin
        pending_m = 1'b0;
        if (ld_idx >= 0) hs.lz_blank_en = vecs[ld_idx].lz;
      end
      @(negedge clk);
    end
    hs.load = 1'b0;
    frame_no++;
    if (q.size() > 0) cur = q.pop_front();
  endtask

  initial begin
    zero_vec = '{value:16'h0000, lz:1'b0,
                 seg:{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                 an:{4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[0] = '{value:16'h1234, lz:1'b0,
                seg:{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                an:{4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[1] = '{value:16'h0050, lz:1'b1,
                seg:{7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000},
                an:{4'b1111, 4'b1111, 4'b1101, 4'b1110}};
    vecs[2] = '{value:16'h00A7, lz:1'b0,
                seg:{7'b1000000, 7'b1000000, 7'b1111111, 7'b1111000},
                an:{4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[3] = '{value:16'h8000, lz:1'b1,
                seg:{7'b0000000, 7'b1000000, 7'b1000000, 7'b1000000},
                an:{4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[4] = '{value:16'h0000, lz:1'b1,
                seg:{7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000},
                an:{4'b1111, 4'b1111, 4'b1111, 4'b1110}};
    vecs[5] = '{value:16'h5678, lz:1'b0,
                seg:{7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000},
                an:{4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[6] = '{value:16'h0906, lz:1'b1,
                seg:{7'b1111111, 7'b0010000, 7'b1000000, 7'b0000010},
                an:{4'b1111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[7] = '{value:16'h4321, lz:1'b0,
                seg:{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001},
                an:{4'b0111, 4'b1011, 4'b1101, 4'b1110}};

    rst_n          = 1'b0;
    hs.load        = 1'b0;
    hs.value_in    = '0;
    hs.lz_blank_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst an", {28'd0, an}, 32'hF);
    check("rst seg", {25'd0, seg}, 32'h7F);
    check("rst ready", {31'd0, hs.ready}, 32'd1);
    check("rst digit_idx", {30'd0, digit_idx}, 32'd0);
    check("rst frame_tick", {31'd0, frame_tick}, 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    cur = zero_vec;
    run_frame(cur, -1, -1, -1, 16'h0);

    // Table-driven loads; the first also tries an overlapping 9999 load.
    for (int i = 0; i < 7; i++) begin
      run_frame(cur, 5, i, (i == 0) ? 8 : -1, 16'h9999);
    end
    // Load on the boundary cycle goes straight to the active value.
    run_frame(cur, FRAME - 1, 7, -1, 16'h0);
    run_frame(cur, -1, -1, -1, 16'h0);

    // Reset mid-frame with a pending load.
    for (int c = 0; c < 13; c++) begin
      hs.load = (c == 5);
      hs.value_in = vecs[3].value;
      @(negedge clk);
    end
    hs.load = 1'b0;
    check("pending ready", {31'd0, hs.ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async an", {28'd0, an}, 32'hF);
    check("async seg", {25'd0, seg}, 32'h7F);
    check("async ready", {31'd0, hs.ready}, 32'd1);
    check("async digit_idx", {30'd0, digit_idx}, 32'd0);
    check("async frame_tick", {31'd0, frame_tick}, 32'd0);
    q.delete();
    pending_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cur = zero_vec;
    run_frame(cur, -1, -1, -1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexes NUM_DIGITS common-anode 7-segment digits through one shared BCD-to-7-segment decoder.
- Sequences the digit slots, inserts an anti-ghosting blank interval between digits, and optionally suppresses leading zeros.
- Accepts new display values through a load/ready handshake. New values take effect only at a frame boundary, so a frame never shows a mix of old and new digits.
- Sits between the counter/arithmetic logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (blank + show); must be > BLANK_CYCLES.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off (>= 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- load  in  1  request to display value_in; accepted when load && ready.
- value_in  in  4*NUM_DIGITS  BCD nibbles; [3:0] = digit 0 (least significant).
- lz_blank_en  in  1  1 = suppress leading zeros.
- ready  out  1  1 = no pending value; a load will be accepted.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}; 7'b1111111 = all off.
- an  out  NUM_DIGITS  active-low anode enables; at most one bit low.
- digit_idx  out  $clog2(NUM_DIGITS)  index of the current slot.
- frame_tick  out  1  one-cycle pulse on the first cycle of each frame.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: seg=7'h7F, an=all 1, digit_idx=0, ready=1, frame_tick=0.
  - Internal: state=BLANK, slot counter=0, active value=0, shadow value=0, pending=0.
- FSM states:
  - BLANK: an=all 1, seg=7'h7F. After BLANK_CYCLES cycles -> SHOW.
  - SHOW: an[digit_idx]=0, seg=decode(active nibble). After REFRESH_DIV-BLANK_CYCLES cycles -> BLANK with digit_idx+1.
  - Wrap-around: digit_idx = NUM_DIGITS-1 wraps to 0.
- Slot counter: counts 0..REFRESH_DIV-1 and resets to 0 at each slot change. One slot = exactly REFRESH_DIV cycles; one frame = NUM_DIGITS*REFRESH_DIV cycles.
- Outputs are registered. They update on the same edge as the state/digit_idx update, with no extra pipeline stage.
- frame_tick: high for exactly the first cycle of the BLANK state of digit 0, including the first cycle after reset release.
- Frame boundary: the last SHOW cycle of digit NUM_DIGITS-1.
- Handshake:
  - load && ready on a non-boundary cycle: value_in -> shadow, pending=1, ready=0 from the next cycle.
  - At the boundary with pending=1: shadow -> active, pending=0, ready=1 on the next cycle.
  - load && ready on the boundary cycle: value_in -> active directly; pending stays 0.
  - load while ready=0: ignored; the shadow is not overwritten.
- Decode:
  - Nibble 0..9 -> standard active-low codes (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000).
  - Nibbles 10..15 -> 7'b1111111 (blank). The anode is still driven for that slot.
- Leading-zero blanking:
  - When lz_blank_en=1, digit i>0 is blanked if nibbles i..NUM_DIGITS-1 of the active value are all 0. In that case seg=7'h7F and an=all 1 for the slot.
  - Digit 0 is never suppressed.
  - lz_blank_en is sampled continuously; a change takes effect at the next SHOW entry.
- Reset asserted mid-frame: immediate return to reset values; any pending shadow value is discarded.

Decomposition:
- Package/header seg7_pkg holds:
  - segment code constants SEG_0..SEG_9 and SEG_OFF=7'h7F;
  - FSM state encoding ST_BLANK=1'b0, ST_SHOW=1'b1;
  - ANODES_OFF helper constant.
- One combinational sub-module, seg7_decoder: 4-bit BCD in, 7-bit active-low segments out, out-of-range -> SEG_OFF. It is instantiated once, fed by the nibble mux on digit_idx.
- Counter, FSM, handshake and blanking logic stay in display_scan_ctrl.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; frame = 32 cycles):
- Reset release, no load -> frame_tick on cycle 0.
  - Each slot: 2 cycles with an=4'b1111 and seg=7'h7F, then 6 cycles with an low on slot digit_idx and seg=7'b1000000.
  - frame_tick again at cycle 32.
- load=1, value_in=16'h1234 mid-frame -> ready=0 next cycle.
  - Digits keep showing 0 until the boundary.
  - Next frame: digit 0 seg=0011001 ("4"), digit 3 seg=1111001 ("1"); ready=1 after the boundary.
- Second load of 16'h9999 while ready=0 -> ignored; the display commits 16'h1234, not 9999.
- lz_blank_en=1, value=16'h0050 -> digits 3 and 2 have an=4'b1111 during SHOW.
  - Digit 1 shows 0010010 ("5"); digit 0 shows 1000000 ("0").
- value=16'h00A7 with lz_blank_en=0 -> digit 1 anode low with seg=7'h7F; digit 0 seg=1111000.
- rst_n pulled low at cycle 13 with a pending load -> an=4'b1111 and seg=7'h7F immediately (asynchronous).
  - ready=1, digit_idx=0; after release the display shows 0000, not the pending value.
